// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data memory responder for the CPU dmem port.
// Define DMEM_STATS_EN to get live rd_count/wr_count; otherwise both ports read 0.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        dmem_resp,
  output logic [31:0] dmem_rdata,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mbe_q, mbe_d;
  logic             write_q, write_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             commit;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic unused_addr_bits;

  assign req_idx          = dmem_address[IDX_W+1:2];
  assign unused_addr_bits = ^{dmem_address[31:IDX_W+2], dmem_address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    write_d = write_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    rd_idx  = idx_q;

    case (state_q)
      S_IDLE: begin
        if (dmem_read || dmem_write) begin
          idx_d   = req_idx;
          wdata_d = dmem_wdata;
          mbe_d   = mem_byte_enable;
          write_d = dmem_write;
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        commit  = write_q;
      end
      default: state_d = S_IDLE;
    endcase

    // With LATENCY==1 the index is not latched yet when entering RESP from IDLE.
    if (state_q == S_IDLE) begin
      rd_idx = req_idx;
    end
    if (state_d == S_RESP && state_q != S_RESP) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mbe_q   <= 4'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents are never reset; a reset during RESP drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mbe_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign dmem_resp  = (state_q == S_RESP);
  assign dmem_rdata = rdata_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == S_RESP) begin
      if (write_q) begin
        wr_count_d = wr_count_q + 32'd1;
      end else begin
        rd_count_d = rd_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for data/protocol
// scenarios and a LATENCY=1 instance for back-to-back response spacing.
module tb_dmem_responder;

  localparam int LAT = 2;

`ifdef DMEM_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  mbe;
  logic        resp;
  logic [31:0] rdata, rd_cnt, wr_cnt;

  logic        rd1, wr1;
  logic [31:0] addr1, wdata1;
  logic [3:0]  mbe1;
  logic        resp1;
  logic [31:0] rdata1, rd_cnt1, wr_cnt1;

  dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .dmem_read(rd), .dmem_write(wr), .dmem_address(addr),
    .dmem_wdata(wdata), .mem_byte_enable(mbe),
    .dmem_resp(resp), .dmem_rdata(rdata),
    .rd_count(rd_cnt), .wr_count(wr_cnt)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
    .clk(clk), .rst(rst),
    .dmem_read(rd1), .dmem_write(wr1), .dmem_address(addr1),
    .dmem_wdata(wdata1), .mem_byte_enable(mbe1),
    .dmem_resp(resp1), .dmem_rdata(rdata1),
    .rd_count(rd_cnt1), .wr_count(wr_cnt1)
  );

  typedef struct {
    bit          chk;
    logic [31:0] data;
    bit          is_wr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_rd   = 0;
  int          exp_wr   = 0;

  // One access on the LATENCY=2 port; expected read word is the pre-access model word.
  task automatic access(input bit do_wr, input bit do_rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit hold);
    exp_t        e;
    exp_t        got;
    int          idx;
    int          cyc;
    logic [31:0] nw;
    idx    = int'(a[11:2]);
    e.chk  = model.exists(idx);
    e.data = e.chk ? model[idx] : 32'h0;
    e.is_wr = do_wr;
    sb.push_back(e);
    if (do_wr && (e.chk || be == 4'hf)) begin
      nw = e.chk ? model[idx] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (be[i]) nw[8*i +: 8] = d[8*i +: 8];
      end
      model[idx] = nw;
    end
    rd = do_rd; wr = do_wr; addr = a; wdata = d; mbe = be;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold && cyc == 1) begin
        rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom; mbe = 4'($urandom);
      end
      if (resp) break;
    end
    got = sb.pop_front();
    n_checks++;
    if (!resp) begin
      n_fail++;
      $display("[TB] FAIL resp_timeout addr=%h: no dmem_resp within %0d cycles", a, cyc);
      rd = 1'b0; wr = 1'b0;
      return;
    end
    if (cyc != LAT) begin
      n_fail++;
      $display("[TB] FAIL latency addr=%h: got %0d cycles, expected %0d", a, cyc, LAT);
    end
    if (got.chk) begin
      n_checks++;
      if (rdata !== got.data) begin
        n_fail++;
        $display("[TB] FAIL rdata addr=%h: got %h, expected %h", a, rdata, got.data);
      end
    end
    if (got.is_wr) exp_wr++;
    else exp_rd++;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    n_checks++;
    if (resp !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL resp_pulse addr=%h: got %b, expected 0", a, resp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd = 0; wr = 0; addr = 0; wdata = 0; mbe = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; mbe1 = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({resp, rdata, rd_cnt, wr_cnt} !== 97'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got resp=%b rdata=%h rd=%0d wr=%0d, expected all 0",
               resp, rdata, rd_cnt, wr_cnt);
    end
    n_checks++;
    if ({resp1, rdata1} !== 33'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state_lat1: got resp=%b rdata=%h, expected 0", resp1, rdata1);
    end
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_write_read();
    access(1, 0, 32'h100, 32'hDEADBEEF, 4'hf, 1);
    access(0, 1, 32'h100, 32'h0, 4'h0, 1);
  endtask

  task automatic test_byte_enable();
    access(1, 0, 32'h101, 32'h000000AA, 4'b0001, 1);
    access(0, 1, 32'h100, 32'h0, 4'h0, 1);
    access(1, 0, 32'h100, 32'h12340000, 4'b1100, 1);
    access(0, 1, 32'h103, 32'h0, 4'h0, 1);
    n_checks++;
    if (rdata !== 32'h1234BEAA) begin
      n_fail++;
      $display("[TB] FAIL byte_merge: got %h, expected 1234beaa", rdata);
    end
  endtask

  task automatic test_wrap();
    access(1, 0, 32'h0, 32'h00000055, 4'hf, 1);
    access(0, 1, 32'h1000, 32'h0, 4'h0, 1);
  endtask

  task automatic test_both_high();
    access(1, 1, 32'h100, 32'hA5A5A5A5, 4'hf, 1);
    access(0, 1, 32'h100, 32'h0, 4'h0, 1);
  endtask

  task automatic test_no_cancel();
    access(1, 0, 32'h300, 32'hCAFEF00D, 4'hf, 0);
    access(0, 1, 32'h300, 32'h0, 4'h0, 0);
  endtask

  task automatic test_reset_abort();
    int seen;
    access(1, 0, 32'h200, 32'h11223344, 4'hf, 1);
    wr = 1'b1; rd = 1'b0; addr = 32'h200; wdata = 32'hFFFFFFFF; mbe = 4'hf;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr = 1'b0;
    exp_rd = 0; exp_wr = 0;
    n_checks++;
    if ({resp, rd_cnt, wr_cnt} !== 65'd0) begin
      n_fail++;
      $display("[TB] FAIL abort_state: got resp=%b rd=%0d wr=%0d, expected 0",
               resp, rd_cnt, wr_cnt);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_resp: got %0d resp cycles, expected 0", seen);
    end
    access(0, 1, 32'h200, 32'h0, 4'h0, 1);
  endtask

  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0;
    access(0, 1, 32'h100, 32'h0, 4'h0, 1);
    access(1, 0, 32'h0, 32'hFFFFFFFF, 4'b0000, 1);
    access(0, 1, 32'h200, 32'h0, 4'h0, 1);
    access(1, 0, 32'h4, 32'h87654321, 4'hf, 1);
    access(0, 1, 32'h0, 32'h0, 4'h0, 1);
    n_checks++;
    if (rd_cnt !== (STATS_EN ? 32'(exp_rd) : 32'd0)) begin
      n_fail++;
      $display("[TB] FAIL rd_count: got %0d, expected %0d", rd_cnt, STATS_EN ? exp_rd : 0);
    end
    n_checks++;
    if (wr_cnt !== (STATS_EN ? 32'(exp_wr) : 32'd0)) begin
      n_fail++;
      $display("[TB] FAIL wr_count: got %0d, expected %0d", wr_cnt, STATS_EN ? exp_wr : 0);
    end
    n_checks++;
    if (exp_rd != 3 || exp_wr != 2) begin
      n_fail++;
      $display("[TB] FAIL stats_mix: got %0d reads %0d writes completed, expected 3 and 2",
               exp_rd, exp_wr);
    end
  endtask

  task automatic test_back_to_back();
    rd1 = 1'b1; addr1 = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) addr1 = 32'h4;
      n_checks++;
      if (resp1 !== k[0]) begin
        n_fail++;
        $display("[TB] FAIL b2b_resp cycle %0d: got %b, expected %b", k, resp1, k[0]);
      end
    end
    rd1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_both_high();
    test_no_cancel();
    test_reset_abort();
    test_stats();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the CPU memory stage's dmem request interface: accepts one read or write at a time, waits a fixed configurable latency, returns a single-cycle `dmem_resp` with registered read data, and commits byte-enabled writes to an internal word array. It sits on the CPU's data-side bus in place of a cache or memory model. It serves as the simulation/FPGA data store and as the reference responder for memory-stage verification.

## Interface
- `LATENCY`, default 2: cycles from request acceptance to `dmem_resp`; legal range 1..15.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dmem_read` input 1: read request, held by initiator until `dmem_resp`.
- `dmem_write` input 1: write request, held by initiator until `dmem_resp`.
- `dmem_address` input 32: byte address; word index = `dmem_address[log2(DEPTH_WORDS)+1:2]`.
- `dmem_wdata` input 32: write data, lane-aligned.
- `mem_byte_enable` input 4: write byte lanes; ignored for reads.
- `dmem_resp` output 1: one-cycle completion pulse.
- `dmem_rdata` output 32: read word, valid in the `dmem_resp` cycle.
- `rd_count` output 32: completed reads (statistics).
- `wr_count` output 32: completed writes (statistics).

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if `dmem_read | dmem_write` is high at an edge, latch address word index, wdata, mbe, and kind (write if `dmem_write`, else read). Load the down-counter with `LATENCY-1`. Go to RESP if `LATENCY==1`, else BUSY.
- BUSY: decrement the counter each edge; go to RESP on the edge where the counter is 1.
- Read data is sampled from the array at the edge entering RESP into the `dmem_rdata` register.
- RESP: `dmem_resp`=1 for exactly this cycle. A write commits at the edge leaving RESP: for each i with mbe[i]=1, byte i is written from latched wdata[8i+7:8i]. Then go to IDLE.
- Both `dmem_read` and `dmem_write` high: treated as a write. `dmem_rdata` returns the pre-write word.
- Write with mbe=0000: no array change; still responds and counts.
- Reads return the full word regardless of address[1:0]; byte/half extraction is the initiator's job.
- Address bits above the index and bits [1:0] are ignored, so indexing wraps modulo `DEPTH_WORDS`.
- Request inputs are not re-examined after acceptance. Deassertion or change mid-flight does not cancel: the latched access completes, responds, and commits.
- The array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `dmem_resp`=0, `dmem_rdata`=0, counter=0, `rd_count`=0, `wr_count`=0.
- Request first seen high at edge E: `dmem_resp` is high in cycle E+LATENCY.
- Back-to-back: a request present in the cycle after RESP is accepted in that cycle, which is IDLE. Sustained throughput is one access per LATENCY+1 cycles.
- Read-after-write to the same word: the read, accepted in the cycle after the write's RESP, returns the new data.
- `dmem_rdata` holds its last value outside RESP.
- `rst` high in BUSY or RESP: return to IDLE at that edge, `dmem_resp`=0. A pending write is not committed and counters are cleared.

## Configuration
- `DMEM_STATS_EN` defined: `rd_count`/`wr_count` increment at the edge leaving RESP for reads/writes respectively, and wrap at 2^32.
- `DMEM_STATS_EN` undefined: both ports are present and tied to 0, and no counter flops exist.

## Test plan
- Write 0xDEADBEEF, mbe 1111, address 0x100, then read 0x100 (LATENCY=2) -> each `dmem_resp` 2 cycles after request. Read returns 0xDEADBEEF.
- After the above, write 0x000000AA, mbe 0001, address 0x101, then read 0x100 -> 0xDEADBEAA. Write 0x12340000, mbe 1100, then read -> 0x1234BEAA.
- LATENCY=1, back-to-back reads of 0x0 and 0x4 held continuously -> resp pulses in cycles 1 and 3, never two consecutive resp cycles.
- Write 0x55 to address 0x0, then `DEPTH_WORDS`=1024 read of 0x1000 -> returns 0x55 (wrap).
- Write 0xFFFFFFFF to 0x200 with `rst` pulsed during BUSY -> no resp. A subsequent read of 0x200 returns the prior contents, and counters read 0.
- With `DMEM_STATS_EN`: 3 reads + 2 writes (one with mbe 0000) -> `rd_count`=3, `wr_count`=2. Without the macro -> both 0.
